// File: rtl/maindec_fsm.sv
// Multicycle RV32I main decoder FSM.
// Sequences FETCH/DECODE/execute/writeback and drives datapath control.
module maindec_fsm #(
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1,
  parameter bit MEM_WAIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       IllegalOp
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_EXECI   = 4'd7;
  localparam logic [3:0] S_LUI     = 4'd8;
  localparam logic [3:0] S_JALRADR = 4'd9;
  localparam logic [3:0] S_JAL     = 4'd10;
  localparam logic [3:0] S_ALUWB   = 4'd11;
  localparam logic [3:0] S_BEQ     = 4'd12;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_dec;
  logic       w_legal;
  logic       w_rdy;

  assign w_rdy = MemReady | ~MEM_WAIT;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Opcode dispatch target and legality, used only in DECODE.
  always_comb begin
    w_dec   = S_FETCH;
    w_legal = 1'b1;
    case (op)
      OP_LW,
      OP_SW:    w_dec = S_MEMADR;
      OP_R:     w_dec = S_EXECR;
      OP_I:     w_dec = S_EXECI;
      OP_BEQ:   w_dec = S_BEQ;
      OP_JAL:   w_dec = S_JAL;
      OP_JALR: begin
        if (EN_JALR) w_dec = S_JALRADR;
        else         w_legal = 1'b0;
      end
      OP_LUI: begin
        if (EN_UPPER) w_dec = S_LUI;
        else          w_legal = 1'b0;
      end
      OP_AUIPC: begin
        if (EN_UPPER) w_dec = S_ALUWB;
        else          w_legal = 1'b0;
      end
      default:  w_legal = 1'b0;
    endcase
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE:  w_next = w_dec;
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: w_next = w_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_rdy ? S_FETCH : S_MEMWR;
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
      S_LUI:     w_next = S_ALUWB;
      S_JALRADR: w_next = S_JAL;
      S_JAL:     w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BEQ:     w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Per-state datapath control; only FETCH loads are gated by memory.
  always_comb begin
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    IllegalOp = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = w_rdy & ~reset;
        PCUpdate  = w_rdy & ~reset;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        IllegalOp = ~w_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:     ImmSrc = 3'b001;
      OP_BEQ:    ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI,
      OP_AUIPC:  ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_maindec_fsm.sv
// Testbench for maindec_fsm.
// Three configurations share stimulus; one is checked at a time.
module tb_maindec_fsm;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RT    = 7'b0110011;
  localparam logic [6:0] IT    = 7'b0010011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       MemReady;

  logic [17:0] outv [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      logic       rw, mw, ir, pu, br, as, il;
      logic [1:0] sa, sb, rs, ao;
      logic [2:0] im;
      maindec_fsm #(
        .EN_JALR (g != 2),
        .EN_UPPER(g != 2),
        .MEM_WAIT(g == 1)
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .MemReady (MemReady),
        .RegWrite (rw),
        .MemWrite (mw),
        .IRWrite  (ir),
        .PCUpdate (pu),
        .Branch   (br),
        .AdrSrc   (as),
        .ALUSrcA  (sa),
        .ALUSrcB  (sb),
        .ResultSrc(rs),
        .ALUOp    (ao),
        .ImmSrc   (im),
        .IllegalOp(il)
      );
      assign outv[g] = {rw, mw, ir, pu, br, as, sa, sb, rs, ao, im, il};
    end
  endgenerate

  always #5 clk = ~clk;

  int          sel;
  bit          exp_on;
  logic [17:0] exp_v;
  string       exp_n;
  int          nvec = 0;
  int          nbad = 0;

  // Expected control word for a named phase of instruction execution.
  function automatic logic [17:0] ctl(string ph, bit rdy, logic [6:0] o);
    logic       rw, mw, ir, pu, br, as, il;
    logic [1:0] sa, sb, rs, ao;
    logic [2:0] im;
    rw = 0; mw = 0; ir = 0; pu = 0; br = 0; as = 0; il = 0;
    sa = 0; sb = 0; rs = 0; ao = 0;
    case (o)
      SW:          im = 3'd1;
      BEQ:         im = 3'd2;
      JAL:         im = 3'd3;
      LUI, AUIPC:  im = 3'd4;
      default:     im = 3'd0;
    endcase
    case (ph)
      "RESET":   begin sb = 2; rs = 2; end
      "FETCH":   begin sb = 2; rs = 2; ir = rdy; pu = rdy; end
      "DECODE":  begin sa = 1; sb = 1; end
      "ILLEGAL": begin sa = 1; sb = 1; il = 1; end
      "MEMADR":  begin sa = 2; sb = 1; end
      "MEMREAD": as = 1;
      "MEMWB":   begin rs = 1; rw = 1; end
      "MEMWR":   begin as = 1; mw = 1; end
      "EXECR":   begin sa = 2; ao = 2; end
      "EXECI":   begin sa = 2; sb = 1; ao = 2; end
      "LUI":     begin sa = 3; sb = 1; end
      "JALRADR": begin sa = 2; sb = 1; end
      "JAL":     begin sa = 1; sb = 2; pu = 1; end
      "ALUWB":   rw = 1;
      "BEQ":     begin sa = 2; ao = 1; br = 1; end
      default:   ;
    endcase
    return {rw, mw, ir, pu, br, as, sa, sb, rs, ao, im, il};
  endfunction

  // Per-cycle check of the selected configuration.
  always @(negedge clk) begin
    if (exp_on) begin
      nvec++;
      if (outv[sel] !== exp_v) begin
        nbad++;
        $display("FAIL %s cfg%0d got %h want %h t=%0t",
                 exp_n, sel, outv[sel], exp_v, $time);
      end
    end
  end

  task automatic pin(string n, logic [17:0] got, logic [17:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask

  task automatic step(string ph, bit rdy, logic [6:0] o);
    op = o;
    if (sel == 1) MemReady = rdy;
    else          MemReady = 1'($urandom_range(0, 1));
    exp_v  = ctl(ph, (sel == 1) ? rdy : 1'b1, o);
    exp_n  = ph;
    exp_on = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    MemReady = 1'($urandom_range(0, 1));
    exp_v    = ctl("RESET", 1'b1, op);
    exp_n    = "RESET";
    exp_on   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Plan one instruction as a list of phases, then play it.
  task automatic run(logic [6:0] o, int fw, int mw, int cpi);
    string      ph[$];
    bit         rd[$];
    bit         ej, eu, ill;
    int         n;
    logic [6:0] ov;
    ej  = (sel != 2);
    eu  = (sel != 2);
    ill = 1'b0;
    for (int i = 0; i < fw; i++) begin
      ph.push_back("FETCH"); rd.push_back(1'b0);
    end
    ph.push_back("FETCH");  rd.push_back(1'b1);
    ph.push_back("DECODE"); rd.push_back(1'b1);
    case (o)
      LW: begin
        ph.push_back("MEMADR"); rd.push_back(1'b1);
        for (int i = 0; i < mw; i++) begin
          ph.push_back("MEMREAD"); rd.push_back(1'b0);
        end
        ph.push_back("MEMREAD"); rd.push_back(1'b1);
        ph.push_back("MEMWB");   rd.push_back(1'b1);
      end
      SW: begin
        ph.push_back("MEMADR"); rd.push_back(1'b1);
        for (int i = 0; i < mw; i++) begin
          ph.push_back("MEMWR"); rd.push_back(1'b0);
        end
        ph.push_back("MEMWR"); rd.push_back(1'b1);
      end
      RT: begin
        ph.push_back("EXECR"); rd.push_back(1'b1);
        ph.push_back("ALUWB"); rd.push_back(1'b1);
      end
      IT: begin
        ph.push_back("EXECI"); rd.push_back(1'b1);
        ph.push_back("ALUWB"); rd.push_back(1'b1);
      end
      BEQ: begin
        ph.push_back("BEQ"); rd.push_back(1'b1);
      end
      JAL: begin
        ph.push_back("JAL");   rd.push_back(1'b1);
        ph.push_back("ALUWB"); rd.push_back(1'b1);
      end
      JALR: begin
        if (ej) begin
          ph.push_back("JALRADR"); rd.push_back(1'b1);
          ph.push_back("JAL");     rd.push_back(1'b1);
          ph.push_back("ALUWB");   rd.push_back(1'b1);
        end else ill = 1'b1;
      end
      LUI: begin
        if (eu) begin
          ph.push_back("LUI");   rd.push_back(1'b1);
          ph.push_back("ALUWB"); rd.push_back(1'b1);
        end else ill = 1'b1;
      end
      AUIPC: begin
        if (eu) begin
          ph.push_back("ALUWB"); rd.push_back(1'b1);
        end else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) ph[ph.size() - 1] = "ILLEGAL";
    n = ph.size() - fw - mw;
    nvec++;
    if (n != cpi) begin
      nbad++;
      $display("FAIL cpi op=%b got %0d want %0d", o, n, cpi);
    end
    foreach (ph[i]) begin
      if (ph[i] == "DECODE" || ph[i] == "ILLEGAL" || ph[i] == "MEMADR")
        ov = o;
      else
        ov = 7'($urandom);
      step(ph[i], rd[i], ov);
    end
  endtask

  initial begin
    reset    = 1'b1;
    op       = LW;
    MemReady = 1'b1;
    sel      = 0;
    exp_on   = 1'b0;
    exp_v    = '0;
    exp_n    = "";
    #2;
    pin("reset_state", outv[0],
        {6'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0});
    @(posedge clk);
    #1;
    do_reset();
    run(LW,    0, 0, 5);
    run(SW,    0, 0, 4);
    run(RT,    0, 0, 4);
    run(IT,    0, 0, 4);
    run(BEQ,   0, 0, 3);
    run(JAL,   0, 0, 4);
    run(JALR,  0, 0, 5);
    run(LUI,   0, 0, 4);
    run(AUIPC, 0, 0, 3);
    run(7'b0000000, 0, 0, 2);
    run(7'b1110011, 0, 0, 2);
    run(LW,    0, 0, 5);

    sel = 1;
    do_reset();
    run(SW, 2, 3, 4);
    run(LW, 1, 2, 5);
    run(RT, 0, 0, 4);
    run(SW, 0, 0, 4);

    // Abort a stalled store with an asynchronous reset.
    step("FETCH",  1'b1, 7'($urandom));
    step("DECODE", 1'b1, SW);
    step("MEMADR", 1'b1, SW);
    step("MEMWR",  1'b0, 7'($urandom));
    exp_on   = 1'b0;
    MemReady = 1'b0;
    #1;
    pin("memwr_before_rst", {17'b0, outv[1][16]}, 18'd1);
    reset = 1'b1;
    #1;
    pin("memwr_async_rst", {17'b0, outv[1][16]}, 18'd0);
    pin("ctl_async_rst", outv[1], ctl("RESET", 1'b1, op));
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(LW, 0, 1, 5);

    sel = 2;
    do_reset();
    run(JALR,  0, 0, 2);
    run(LUI,   0, 0, 2);
    run(AUIPC, 0, 0, 2);
    run(LW,    0, 0, 5);
    run(BEQ,   0, 0, 3);
    exp_on = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/maindec_fsm.md
Name: maindec_fsm

Overview:
Multicycle main decoder: a Moore/Mealy FSM that replaces the single-cycle opcode-to-control lookup for the multicycle RV32I core. It sequences every instruction through FETCH, DECODE and per-class execute/writeback states, and drives the shared-ALU/shared-memory datapath control. It sits beside the unchanged ALU decoder, which consumes ALUOp.
Generalised over the single-cycle decoder:
- optional JALR/LUI/AUIPC support
- optional memory wait handshake
- illegal-opcode flag

Parameters:
EN_JALR, 1, 1 = decode jalr (op 1100111); 0 = treat it as illegal.
EN_UPPER, 1, 1 = decode lui (0110111) and auipc (0010111); 0 = treat them as illegal.
MEM_WAIT, 0, 1 = honour MemReady in memory states; 0 = MemReady is ignored and treated as 1.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; forces state to FETCH.
op  input  7  opcode from the instruction register.
MemReady  input  1  memory access completes this cycle.
RegWrite  output  1  register file write enable.
MemWrite  output  1  data memory write enable.
IRWrite  output  1  instruction register / OldPC load.
PCUpdate  output  1  unconditional PC load.
Branch  output  1  beq compare state; datapath forms PCWrite = PCUpdate | (Branch & Zero).
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUOp  output  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
ImmSrc  output  3  combinational from op: I = 000, S = 001, B = 010, J = 011, U = 100; otherwise 000.
IllegalOp  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Behaviour:
- State register updates on posedge clk; asynchronous reset sets state = FETCH.
- Outputs are a function of state only, except the MemReady gating described below. Any output not listed for a state is 0.
- While reset is high, outputs equal the FETCH values with IRWrite = PCUpdate = 0.
- "rdy" means (MemReady | ~MEM_WAIT).

States, their outputs, and next state:
- FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10, IRWrite = rdy, PCUpdate = rdy. Next: rdy ? DECODE : FETCH.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch/jal/auipc target into ALUOut). Next state by op:
  - lw or sw -> MEMADR
  - R-type (0110011) -> EXECR
  - I-ALU (0010011) -> EXECI
  - beq (1100011) -> BEQ
  - jal -> JAL
  - jalr -> JALRADR (when EN_JALR)
  - lui -> LUI (when EN_UPPER)
  - auipc -> ALUWB (when EN_UPPER)
  - anything else -> FETCH, with IllegalOp = 1 for this cycle.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Next: lw ? MEMREAD : MEMWR.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Next: rdy ? MEMWB : MEMREAD.
- MEMWB: ResultSrc = 01, RegWrite = 1. Next: FETCH.
- MEMWR: AdrSrc = 1, ResultSrc = 00, MemWrite = 1, held for every wait cycle. Next: rdy ? FETCH : MEMWR.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Next: ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Next: ALUWB.
- LUI: ALUSrcA = 11, ALUSrcB = 01, ALUOp = 00. Next: ALUWB.
- JALRADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Next: JAL.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1. Next: ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1. Next: FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1. Next: FETCH.

Rules:
- op is sampled only in DECODE and MEMADR; op changes in other states have no effect.
- Cycles per instruction with MEM_WAIT = 0:
  - lw: 5
  - sw, R-type, I-ALU, jal, lui: 4
  - jalr: 5
  - beq, auipc: 3
  - illegal: 2
- Each MemReady-low cycle adds one cycle in FETCH, MEMREAD or MEMWR.
- Reset asserted mid-instruction aborts it immediately. No RegWrite/MemWrite is issued after reset rises. The first post-reset cycle is FETCH.
- The state encoding must be a safe enum; an unreachable encoding returns to FETCH.

Test Plan:
- Reset high, then low with MEM_WAIT = 0 and op = 0000011 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 and ResultSrc = 01 only in cycle 5; IRWrite = 1 only in cycle 1.
- MEM_WAIT = 1, sw, MemReady low for 3 cycles in MEMWR -> MemWrite held high for 4 cycles, then FETCH; FETCH with MemReady = 0 holds IRWrite = PCUpdate = 0.
- jalr with EN_JALR = 1 -> DECODE, JALRADR (ALUSrcA = 10, ALUSrcB = 01), JAL (PCUpdate = 1), ALUWB (RegWrite = 1); same op with EN_JALR = 0 -> IllegalOp = 1 in DECODE, then FETCH.
- lui -> ImmSrc = 100, ALUSrcA = 11 in LUI, 4 cycles total; auipc -> DECODE goes directly to ALUWB, 3 cycles.
- beq -> Branch = 1, ALUOp = 01 for exactly one cycle; R-type -> ALUOp = 10, ALUSrcB = 00 in EXECR.
- Assert reset asynchronously mid-MEMWR with MemWrite = 1 -> MemWrite falls without a clock edge; state = FETCH on release.
